// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the multiply/divide sequencing controller
package muldiv_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  localparam int MAX_CYCLES_DEFAULT = 40;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN
  } state_e;

endpackage

// File: rtl/muldiv_watchdog.sv
// rtl/muldiv_watchdog.sv - run-cycle counter; expired marks the last allowed RUN cycle
module muldiv_watchdog
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates so a stuck enable can never wrap back into the live range.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(MAX_CYCLES))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == CW'(MAX_CYCLES - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - sequences MULT/DIV units, owns HI/LO, raises pipeline stall
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  input  logic        rd_req,
  output logic        ready,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        div0_exc,
  output logic        err_timeout,
  output logic        mul_start,
  output logic        div_start,
  output logic        unit_abort,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        mul_done,
  input  logic        div_done,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo
);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] unit_a_q, unit_a_d, unit_b_q, unit_b_d;
  logic        done_q, done_d, div0_exc_q, div0_exc_d, err_timeout_q, err_timeout_d;
  logic        mul_start_q, mul_start_d, div_start_q, div_start_d;
  logic        unit_abort_q, unit_abort_d;
  logic        wd_expired, run_done;
  logic [31:0] res_hi, res_lo;

  muldiv_watchdog #(.MAX_CYCLES(MAX_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q == IDLE),
    .en      (state_q != IDLE),
    .expired (wd_expired)
  );

  // Only the unit that was launched may complete the operation.
  assign run_done = (state_q == MUL_RUN) ? mul_done : div_done;
  assign res_hi   = (state_q == MUL_RUN) ? mul_hi : div_hi;
  assign res_lo   = (state_q == MUL_RUN) ? mul_lo : div_lo;

  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    unit_a_d      = unit_a_q;
    unit_b_d      = unit_b_q;
    done_d        = 1'b0;
    div0_exc_d    = 1'b0;
    err_timeout_d = 1'b0;
    mul_start_d   = 1'b0;
    div_start_d   = 1'b0;
    unit_abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid && !flush) begin
          case (op)
            OP_MULT: begin
              unit_a_d    = opa;
              unit_b_d    = opb;
              mul_start_d = 1'b1;
              state_d     = MUL_RUN;
            end
            OP_DIV: begin
              if (opb == 32'd0) begin
                div0_exc_d = 1'b1;
              end else begin
                unit_a_d    = opa;
                unit_b_d    = opb;
                div_start_d = 1'b1;
                state_d     = DIV_RUN;
              end
            end
            OP_MTHI: hi_d = opa;
            OP_MTLO: lo_d = opa;
            default: ;
          endcase
        end
      end
      MUL_RUN, DIV_RUN: begin
        // Flush outranks a same-cycle completion; completion outranks the watchdog.
        if (flush) begin
          unit_abort_d = 1'b1;
          state_d      = IDLE;
        end else if (run_done) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (wd_expired) begin
          err_timeout_d = 1'b1;
          unit_abort_d  = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hi_q          <= '0;
      lo_q          <= '0;
      unit_a_q      <= '0;
      unit_b_q      <= '0;
      done_q        <= 1'b0;
      div0_exc_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      mul_start_q   <= 1'b0;
      div_start_q   <= 1'b0;
      unit_abort_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      unit_a_q      <= unit_a_d;
      unit_b_q      <= unit_b_d;
      done_q        <= done_d;
      div0_exc_q    <= div0_exc_d;
      err_timeout_q <= err_timeout_d;
      mul_start_q   <= mul_start_d;
      div_start_q   <= div_start_d;
      unit_abort_q  <= unit_abort_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign stall       = ((op_valid && (op == OP_MULT || op == OP_DIV)) || rd_req) && !ready;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign unit_a      = unit_a_q;
  assign unit_b      = unit_b_q;
  assign done        = done_q;
  assign div0_exc    = div0_exc_q;
  assign err_timeout = err_timeout_q;
  assign mul_start   = mul_start_q;
  assign div_start   = div_start_q;
  assign unit_abort  = unit_abort_q;

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the CPU's iterative multiply and divide units. It accepts MULT/DIV/MTHI/MTLO requests from the execute stage, launches the selected unit, and owns the architectural HI/LO registers. It stalls the pipeline while a unit is busy and handles divide-by-zero, pipeline flush and a watchdog timeout. It sits between the execute stage and the Booth multiplier / restoring divider.

## Interface

- MAX_CYCLES, 40, watchdog limit in cycles spent in a RUN state before abort
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- op_valid  in  1  request strobe from execute stage
- op  in  3  0=NOP, 1=MULT, 2=DIV, 3=MTHI, 4=MTLO, others treated as NOP
- opa, opb  in  32 each  operands; MTHI/MTLO use opa
- flush  in  1  cancel any in-flight operation
- rd_req  in  1  MFHI/MFLO is in execute this cycle
- ready  out  1  controller in IDLE and can accept op
- stall  out  1  pipeline stall request
- hi, lo  out  32 each  architectural HI/LO registers
- done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV
- div0_exc, err_timeout  out  1 each  one-cycle error pulses
- mul_start, div_start  out  1 each  one-cycle launch pulses to units
- unit_abort  out  1  one-cycle pulse: units clear internal state
- unit_a, unit_b  out  32 each  registered operands, held stable during RUN
- mul_done, div_done  in  1 each  unit completion pulses
- mul_hi, mul_lo, div_hi, div_lo  in  32 each  unit results, valid with done

## Operation

- States: IDLE, MUL_RUN, DIV_RUN.
- IDLE, op_valid, op=MULT: latch opa/opb into unit_a/unit_b, go to MUL_RUN, pulse mul_start.
- IDLE, op_valid, op=DIV, opb≠0: same as MULT, but go to DIV_RUN and pulse div_start.
- IDLE, op_valid, op=DIV, opb=0: pulse div0_exc. No start pulse; HI/LO unchanged; stay in IDLE.
- IDLE, MTHI/MTLO: write hi/lo from opa on that edge. No busy cycle.
- RUN state, matching *_done: write HI/LO from that unit's results, pulse done, return to IDLE. The non-matching done input is ignored.
- op_valid while not in IDLE: ignored. The requester must hold it until ready.
- flush in any RUN state: pulse unit_abort, go to IDLE, discard result. HI/LO unchanged.
- flush in IDLE: blocks acceptance of a simultaneous op_valid.
- flush and *_done in the same cycle: flush wins, result discarded.
- Watchdog: cycle counter, width clog2(MAX_CYCLES+1). Cleared on RUN entry, increments each RUN cycle. Reaching MAX_CYCLES without done pulses err_timeout and unit_abort, then returns to IDLE with HI/LO unchanged.
- stall = op_valid&&(op==MULT||op==DIV)&&!ready, OR rd_req&&!ready. MFHI/MFLO therefore never read a stale value.
- reset, at any time including mid-RUN: state=IDLE. hi, lo, unit_a, unit_b and counter are 0. All pulses are 0. ready=1.

## Timing

- All outputs registered except ready and stall, which are combinational from state and inputs.
- Accept at edge T. mul_start/div_start is high during cycle T+1, and ready is low from T+1.
- Unit done sampled at edge D. hi/lo are valid and done is high during D+1, and ready=1 in D+1.
- End-to-end latency is unit latency + 2 cycles. A new op is accepted at earliest in cycle D+1.
- div0_exc is high during T+1. err_timeout is high in the cycle after the limit is reached.
- Pulse outputs are exactly one cycle wide.

## Structure

- muldiv_pkg holds:
  - op encodings OP_NOP..OP_MTLO
  - state enum {IDLE, MUL_RUN, DIV_RUN}
  - MAX_CYCLES default constant
- Sub-module muldiv_watchdog contains the clear/enable counter and the expiry flag. It is parameterised by MAX_CYCLES.
- Multiplier and divider remain separate modules instantiated beside this block, not inside it.

## Test plan

- MULT opa=7, opb=-3, unit model answers after 32 cycles with hi=FFFFFFFF, lo=FFFFFFEB -> mul_start one pulse in T+1; stall held while rd_req=1; hi/lo match in D+1; done one pulse.
- DIV opa=100, opb=0 -> div0_exc pulse in T+1, no div_start, hi/lo keep prior values (e.g. 0x12345678/0x9ABCDEF0 from prior MTHI/MTLO).
- DIV 100/7 with flush asserted 5 cycles after start -> unit_abort pulse, IDLE next cycle, no done, hi/lo unchanged; flush coincident with div_done -> same.
- MULT with unit never responding, MAX_CYCLES=40 -> err_timeout and unit_abort high in cycle 41 after entry, ready=1 after.
- Back-to-back MULT then MTHI opa=0xCAFEF00D held on op_valid -> MTHI waits until ready, then hi=0xCAFEF00D while lo keeps MULT low word.
- Reset asserted mid-DIV_RUN -> hi=lo=0, ready=1, no pulses asynchronously; a MULT accepted after release behaves normally.
